// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the sequential signed divider (booth_divider).
//   div_state_e     : divider FSM states (IDLE, CALC, FIX)
//   DIV0_QUOTIENT   : quotient returned on divide-by-zero (all ones, i.e. -1),
//                     sliced to the operand width by the user
//   div_latency()   : accept-to-done latency in clock edges for a given width
// -----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    // One restoring step per operand bit plus a single sign-correction edge.
    function automatic int unsigned div_latency(input int unsigned width);
        return width + 32'd1;
    endfunction

endpackage

// File: rtl/booth_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// Combinational single restoring shift-subtract step on magnitudes.
//   rem_i     : current partial remainder (always < divisor magnitude)
//   dvs_i     : divisor magnitude, WIDTH+1 bits so 2^(WIDTH-1) is representable
//   bit_i     : next dividend bit shifted into the remainder
//   rem_o     : partial remainder after this step
//   quo_bit_o : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH:0]   dvs_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quo_bit_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Shift in the next dividend bit and keep the trial difference when it is
    // non-negative. Because rem_i < dvs_i, the shifted value is below
    // 2*dvs_i <= 2^WIDTH, so bit WIDTH of the trial is a true sign bit.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        trial_s   = shifted_s - dvs_i;
        if (trial_s[WIDTH] == 1'b0) begin
            rem_o     = trial_s[WIDTH-1:0];
            quo_bit_o = 1'b1;
        end else begin
            rem_o     = shifted_s[WIDTH-1:0];
            quo_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/booth_divider.sv
// -----------------------------------------------------------------------------
// booth_divider
// Sequential signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per clock, followed by one sign-correction edge. Quotient
// truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk, rst_n          : rising-edge clock, async active-low reset
//   start               : request, sampled only while busy=0
//   dividend, divisor   : signed operands, captured on the accepting edge
//   busy                : high from the accepting edge until done
//   done                : one-cycle pulse; results held afterwards
//   quotient, remainder : signed results
//   div_by_zero         : divisor was zero (quotient=-1, remainder=dividend)
//   overflow            : -2^(WIDTH-1) / -1 (quotient wraps, remainder=0)
// -----------------------------------------------------------------------------
module booth_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int LAST_STEP = int'(div_latency(WIDTH)) - 2;
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

    div_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_bit_s;

    // Operand magnitudes at WIDTH bits read as unsigned: -2^(WIDTH-1) maps to
    // 2^(WIDTH-1), which still fits.
    always_comb begin
        dvd_mag_s = dividend[WIDTH-1] ? (ZERO_W - dividend) : dividend;
        dvs_mag_s = divisor[WIDTH-1]  ? (ZERO_W - divisor)  : divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .dvs_i     (dvs_q),
        .bit_i     (quo_q[WIDTH-1]),
        .rem_o     (step_rem_s),
        .quo_bit_o (step_bit_s)
    );

    // Next-state, datapath and result logic for IDLE/CALC/FIX.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sign_rem_d = dividend[WIDTH-1];
                    ovf_pend_d = (dividend == MOST_NEG) && (divisor == MINUS_ONE);
                    quo_d      = dvd_mag_s;
                    dvs_d      = {1'b0, dvs_mag_s};
                    rem_d      = ZERO_W;
                    cnt_d      = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end else begin
                    state_d    = IDLE;
                end
            end
            CALC: begin
                // quo_q doubles as the dividend shift register: its MSB feeds
                // the step while the new quotient bit enters at the bottom.
                rem_d = step_rem_s;
                quo_d = {quo_q[WIDTH-2:0], step_bit_s};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(LAST_STEP)) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                // With a zero divisor every step succeeds, so rem_q ends up as
                // |dividend| and the sign fix below restores the dividend.
                remainder_d = sign_rem_q ? (ZERO_W - rem_q) : rem_q;
                if (dvs_q == {(WIDTH+1){1'b0}}) begin
                    quotient_d = DIV0_QUOTIENT[WIDTH-1:0];
                    dz_d       = 1'b1;
                    ovf_d      = 1'b0;
                end else begin
                    quotient_d = sign_quo_q ? (ZERO_W - quo_q) : quo_q;
                    dz_d       = 1'b0;
                    ovf_d      = ovf_pend_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= ZERO_W;
            quo_q       <= ZERO_W;
            dvs_q       <= {(WIDTH+1){1'b0}};
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= ZERO_W;
            remainder_q <= ZERO_W;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// -----------------------------------------------------------------------------
// tb_booth_divider
// Self-checking bench for booth_divider (WIDTH=8): directed cases, randomized
// operands against an integer-arithmetic reference model, handshake and reset.
// -----------------------------------------------------------------------------
module tb_booth_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Reference: plain signed integer division ({quotient, remainder, dz, ovf}).
    function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
        int   sa, sb, q, r;
        logic dz, ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q = -1; r = sa; dz = 1'b1;
        end else if (sa == -128 && sb == -1) begin
            q = -128; r = 0; ov = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb;
        end
        return {q[7:0], r[7:0], dz, ov};
    endfunction

    function automatic logic [17:0] observed();
        return {quotient, remainder, div_by_zero, overflow};
    endfunction

    // Drive one request and wait (bounded) for done; lat counts edges after E0.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta  [7] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd37};
        logic [7:0]  tb  [7] = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'hFF, 8'h01, 8'd0};
        logic [17:0] exp [7] = '{{8'h0E, 8'h02, 2'b00}, {8'hF2, 8'hFE, 2'b00},
                                 {8'hF2, 8'h02, 2'b00}, {8'h0E, 8'hFE, 2'b00},
                                 {8'h80, 8'h00, 2'b01}, {8'h80, 8'h00, 2'b00},
                                 {8'hFF, 8'h25, 2'b10}};
        int lat;
        logic [17:0] held;
        for (int i = 0; i < 7; i++) begin
            issue(ta[i], tb[i], lat);
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 9", i, lat);
            end
            checks++;
            if (observed() !== exp[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h busy=%b expected %h busy=0",
                         i, observed(), busy, exp[i]);
            end
            held = observed();
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || observed() !== exp[i]) begin
                errors++;
                $display("FAIL directed_hold[%0d]: done=%b got %h expected done=0 %h",
                         i, done, observed(), held);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (i == 0) begin a = 8'h80; b = 8'hFF; end
            issue(a, b, lat);
            checks++;
            if (lat !== 9 || observed() !== model(a, b)) begin
                errors++;
                $display("FAIL random[%0d] %h/%h: lat=%0d got %h expected lat=9 %h",
                         i, a, b, lat, observed(), model(a, b));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy: got %b expected 1", busy);
        end
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 9 || observed() !== model(8'd50, 8'd5)) begin
            errors++;
            $display("FAIL ignore_result: lat=%0d got %h expected lat=9 %h",
                     lat, observed(), model(8'd50, 8'd5));
        end
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_no_second: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'd100, 8'd7, lat);
        checks++;
        if (lat !== 9 || observed() !== model(8'd100, 8'd7)) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d got %h expected lat=9 %h",
                     lat, observed(), model(8'd100, 8'd7));
        end
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy/done=%b expected 10", {busy, done});
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 9 || observed() !== {8'd4, 8'd1, 2'b00}) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d got %h expected lat=9 %h",
                     lat, observed(), {8'd4, 8'd1, 2'b00});
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected 0",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        end
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
        end
        issue(8'd77, 8'd3, lat);
        checks++;
        if (lat !== 9 || observed() !== {8'd25, 8'd2, 2'b00}) begin
            errors++;
            $display("FAIL abort_rerun: lat=%0d got %h expected lat=9 %h",
                     lat, observed(), {8'd25, 8'd2, 2'b00});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed integer divider; the inverse companion of the team's combinational Booth multiplier. It accepts a signed dividend and divisor through a start/done handshake and computes one quotient bit per clock by restoring shift-subtract on magnitudes. It then applies a sign-correction cycle and returns the truncated quotient and remainder. It sits beside the multiplier in the arithmetic datapath and serves control logic that can tolerate a fixed multi-cycle latency.

## Interface
- WIDTH, 8, operand/result width in bits, two's complement; legal range 4..32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  signed dividend; captured on the accepting edge
- divisor  input  WIDTH  signed divisor; captured on the accepting edge
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse; results valid while done=1 and held afterwards
- quotient  output  WIDTH  signed quotient
- remainder  output  WIDTH  signed remainder
- div_by_zero  output  1  result flag, valid with done
- overflow  output  1  result flag, valid with done

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 captures the operands.
  - Records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Loads |dividend| and |divisor| as (WIDTH+1)-bit unsigned values, so -2^(W-1) is representable.
  - Clears the partial remainder and bit counter, sets busy, and goes to CALC.
- CALC, WIDTH cycles:
  - Shift {rem, quo} left by 1.
  - trial = rem - |divisor| at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
  - Counter counts 0..WIDTH-1, then the block goes to FIX.
- FIX, 1 cycle:
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_r ? -rem : rem.
  - Rounding truncates toward zero, and the remainder takes the dividend's sign.
  - Sets done=1 and busy=0, then returns to IDLE.
- Divisor = 0:
  - The block still runs the full fixed latency.
  - Results: quotient = all ones (-1), remainder = dividend, div_by_zero = 1, overflow = 0.
- Dividend = -2^(W-1) and divisor = -1:
  - Results: quotient = -2^(W-1) (wrapped), remainder = 0, overflow = 1.
- All other inputs give flags = 0. Flags are registered together with quotient and remainder.
- start while busy=1 is ignored. No queueing and no error.

## Timing
- Reset (async assert, synchronous-style release on clk):
  - state = IDLE; busy, done, quotient, remainder and both flags are 0.
  - Reset mid-operation aborts the operation; no done is produced for it.
- Accepting edge E0: start=1 and busy=0. busy reads 1 after E0.
- CALC runs edges E1..EWIDTH. FIX is evaluated at edge E(WIDTH+1).
- After E(WIDTH+1):
  - done=1, busy=0, results valid.
  - Fixed latency is WIDTH+1 edges, i.e. 9 for WIDTH=8.
- done is high for exactly one cycle. Outputs hold their values until the next FIX edge.
- Back-to-back: start=1 during the done cycle is accepted at the next edge, giving a throughput of one result per WIDTH+2 cycles.
- Operand inputs are don't-care except at the accepting edge.

## Structure
- Shared package arith_pkg:
  - State enum (IDLE, CALC, FIX).
  - Localparam helper for latency: WIDTH+1.
  - Divide-by-zero quotient constant (all ones).
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: rem, |divisor|, incoming bit.
  - Outputs: next rem, quotient bit.
- The top level holds the FSM, counter, operand/sign registers and output registers.

## Test plan
- WIDTH=8, 100 / 7 -> quotient=14, remainder=2, flags 0, done exactly 9 edges after the accepting edge.
- Sign combinations:
  - -100 / 7 -> quotient=-14, remainder=-2.
  - 100 / -7 -> quotient=-14, remainder=2.
  - -100 / -7 -> quotient=14, remainder=-2.
- -128 / -1 -> quotient=-128 (8'h80), remainder=0, overflow=1. Then -128 / 1 -> quotient=-128, remainder=0, overflow=0.
- 37 / 0 -> quotient=8'hFF, remainder=37, div_by_zero=1, latency 9.
- Handshake:
  - Pulse start with 50/5, then assert start with 9/2 on the 3rd busy cycle -> only 10 r 0 is returned.
  - Start 9/2 in the done cycle -> next done gives 4 r 1 exactly 9 edges later.
- Reset:
  - Drop rst_n at the 5th CALC cycle of 77/3 -> all outputs 0 immediately, no done.
  - After release, 77/3 -> 25 r 2.
